// File: rtl/alu_simd_pipelined_acc_if.sv
// Operand/config/result bundle for the pipelined SIMD ALU with accumulator.
// The master drives operands and configuration; the slave (the ALU) returns results.
interface alu_simd_pipelined_acc_if #(
    parameter int LANE_W    = 6,
    parameter int NUM_LANES = 5
);
    localparam int DATA_W = LANE_W * NUM_LANES;

    logic                   ce;
    logic                   in_valid;
    logic [1:0]             USE_SIMD;
    logic [1:0]             op;
    logic                   acc;
    logic                   acc_clr;
    logic                   CIN;
    logic [DATA_W-1:0]      X;
    logic [DATA_W-1:0]      Y;
    logic [DATA_W-1:0]      Z;
    logic [DATA_W-1:0]      S;
    logic [2*NUM_LANES-1:0] COUT;
    logic                   out_valid;

    modport master (
        output ce, in_valid, USE_SIMD, op, acc, acc_clr, CIN, X, Y, Z,
        input  S, COUT, out_valid
    );

    modport slave (
        input  ce, in_valid, USE_SIMD, op, acc, acc_clr, CIN, X, Y, Z,
        output S, COUT, out_valid
    );
endinterface

// File: rtl/alu_simd_pipelined_acc.sv
// Two-stage SIMD ALU: 3-operand add with per-group 2-bit carry chains, or bitwise ops,
// with the result register P optionally substituted for Z to accumulate.
module alu_simd_pipelined_acc #(
    parameter int LANE_W    = 6,
    parameter int NUM_LANES = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    alu_simd_pipelined_acc_if.slave   bus
);
    localparam int DATA_W = LANE_W * NUM_LANES;

    logic [DATA_W-1:0]      x_p1, y_p1, z_p1;
    logic                   cin_p1, acc_p1, clr_p1, vld_p1;
    logic [1:0]             op_p1, simd_p1;

    logic [DATA_W-1:0]      p_p2;
    logic [2*NUM_LANES-1:0] cout_p2;
    logic                   vld_p2;

    logic [DATA_W-1:0]      z_eff;
    logic [DATA_W-1:0]      sum_res;
    logic [2*NUM_LANES-1:0] sum_cout;
    logic [DATA_W-1:0]      result;
    logic [2*NUM_LANES-1:0] result_cout;
    logic [1:0]             carry;
    logic [1:0]             lane_ci;
    logic [LANE_W+1:0]      lane_sum;

    function automatic logic [LANE_W+1:0] lane_add(
        input logic [LANE_W-1:0] a,
        input logic [LANE_W-1:0] b,
        input logic [LANE_W-1:0] c,
        input logic [1:0]        ci
    );
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {{LANE_W{1'b0}}, ci};
    endfunction

    // USE_SIMD=11 behaves as per-lane grouping
    function automatic logic group_lo(input logic [1:0] simd, input int lane);
        case (simd)
            2'b00:   return lane == 0;
            2'b01:   return (lane % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic group_hi(input logic [1:0] simd, input int lane);
        case (simd)
            2'b00:   return lane == NUM_LANES - 1;
            2'b01:   return ((lane % 2) == 1) || (lane == NUM_LANES - 1);
            default: return 1'b1;
        endcase
    endfunction

    // ---- stage 2: compute from stage-1 registers and P feedback ----
    always_comb begin
        z_eff    = acc_p1 ? (clr_p1 ? '0 : p_p2) : z_p1;
        carry    = 2'b00;
        lane_ci  = 2'b00;
        lane_sum = '0;
        sum_res  = '0;
        sum_cout = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_ci  = group_lo(simd_p1, i) ? {1'b0, cin_p1} : carry;
            lane_sum = lane_add(x_p1[i*LANE_W +: LANE_W], y_p1[i*LANE_W +: LANE_W],
                                z_eff[i*LANE_W +: LANE_W], lane_ci);
            sum_res[i*LANE_W +: LANE_W] = lane_sum[LANE_W-1:0];
            carry = lane_sum[LANE_W+1:LANE_W];
            if (group_hi(simd_p1, i)) sum_cout[2*i +: 2] = carry;
        end

        result      = sum_res;
        result_cout = '0;
        case (op_p1)
            2'b00: result_cout = sum_cout;
            2'b01: result      = x_p1 ^ y_p1 ^ z_eff;
            2'b10: result      = x_p1 & y_p1;
            2'b11: result      = x_p1 | y_p1;
            default: result    = sum_res;
        endcase
    end

    // ---- stage 1 capture and stage 2 result register; ce freezes both ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_p1    <= '0;
            y_p1    <= '0;
            z_p1    <= '0;
            cin_p1  <= 1'b0;
            acc_p1  <= 1'b0;
            clr_p1  <= 1'b0;
            op_p1   <= 2'b00;
            simd_p1 <= 2'b00;
            vld_p1  <= 1'b0;
            p_p2    <= '0;
            cout_p2 <= '0;
            vld_p2  <= 1'b0;
        end else if (bus.ce) begin
            x_p1    <= bus.X;
            y_p1    <= bus.Y;
            z_p1    <= bus.Z;
            cin_p1  <= bus.CIN;
            acc_p1  <= bus.acc;
            clr_p1  <= bus.acc_clr;
            op_p1   <= bus.op;
            simd_p1 <= bus.USE_SIMD;
            vld_p1  <= bus.in_valid;
            vld_p2  <= vld_p1;
            if (vld_p1) begin
                p_p2    <= result;
                cout_p2 <= result_cout;
            end
        end
    end

    assign bus.S         = p_p2;
    assign bus.COUT      = cout_p2;
    assign bus.out_valid = vld_p2;
endmodule

// File: tb/tb_alu_simd_pipelined_acc.sv
// Directed + randomized bench for alu_simd_pipelined_acc with a group-level reference model
// and an in-order expectation queue.
module tb_alu_simd_pipelined_acc;
    localparam int LW = 6;
    localparam int NL = 5;
    localparam int DW = LW * NL;

    typedef struct packed {
        logic [DW-1:0]   s;
        logic [2*NL-1:0] c;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    alu_simd_pipelined_acc_if #(.LANE_W(LW), .NUM_LANES(NL)) bus ();

    alu_simd_pipelined_acc #(.LANE_W(LW), .NUM_LANES(NL)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t          exp_q[$];
    exp_t          cur;
    logic [DW-1:0] pm;
    logic          v1m, v2m;
    int            vectors = 0;
    int            miscompares = 0;

    // Whole-group arithmetic: a group's sum is one wide add; its carry is what spills past the group.
    function automatic exp_t model(input logic [1:0] simd, input logic [1:0] op,
                                   input logic acc, input logic clr, input logic cin,
                                   input logic [DW-1:0] x, input logic [DW-1:0] y,
                                   input logic [DW-1:0] z, input logic [DW-1:0] p);
        exp_t e;
        logic [DW-1:0] zf;
        logic [63:0] mask, tot;
        int gsz, hi, w;
        e  = '0;
        zf = acc ? (clr ? '0 : p) : z;
        case (op)
            2'b00: begin
                gsz = (simd == 2'b00) ? NL : (simd == 2'b01) ? 2 : 1;
                for (int lo = 0; lo < NL; lo += gsz) begin
                    hi   = (lo + gsz > NL) ? NL - 1 : lo + gsz - 1;
                    w    = (hi - lo + 1) * LW;
                    mask = (64'd1 << w) - 64'd1;
                    tot  = ((64'(x) >> (lo*LW)) & mask) + ((64'(y) >> (lo*LW)) & mask)
                         + ((64'(zf) >> (lo*LW)) & mask) + 64'(cin);
                    e.s  = e.s | DW'((tot & mask) << (lo*LW));
                    e.c  = e.c | (2*NL)'((tot >> w) << (2*hi));
                end
            end
            2'b01:   e.s = x ^ y ^ zf;
            2'b10:   e.s = x & y;
            default: e.s = x | y;
        endcase
        return e;
    endfunction

    task automatic check_outputs();
        vectors++;
        assert (bus.out_valid === v2m) else begin
            miscompares++;
            $error("FAIL out_valid: got %b exp %b", bus.out_valid, v2m);
        end
        vectors++;
        assert (bus.S === cur.s) else begin
            miscompares++;
            $error("FAIL S: got %h exp %h", bus.S, cur.s);
        end
        vectors++;
        assert (bus.COUT === cur.c) else begin
            miscompares++;
            $error("FAIL COUT: got %b exp %b", bus.COUT, cur.c);
        end
    endtask

    task automatic tick();
        logic ce_s, iv_s;
        ce_s = bus.ce;
        iv_s = bus.in_valid;
        @(posedge clk);
        #1;
        if (ce_s) begin
            if (v1m) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $error("FAIL scoreboard: got result with no expectation queued, exp queued entry");
                end else begin
                    cur = exp_q.pop_front();
                end
            end
            v2m = v1m;
            v1m = iv_s;
        end
        check_outputs();
    endtask

    task automatic drive(input logic iv, input logic ce_v, input logic [1:0] simd,
                         input logic [1:0] op, input logic acc, input logic clr,
                         input logic cin, input logic [DW-1:0] x,
                         input logic [DW-1:0] y, input logic [DW-1:0] z);
        exp_t e;
        bus.in_valid = iv;
        bus.ce       = ce_v;
        bus.USE_SIMD = simd;
        bus.op       = op;
        bus.acc      = acc;
        bus.acc_clr  = clr;
        bus.CIN      = cin;
        bus.X        = x;
        bus.Y        = y;
        bus.Z        = z;
        if (iv && ce_v) begin
            e  = model(simd, op, acc, clr, cin, x, y, z, pm);
            pm = e.s;
            exp_q.push_back(e);
        end
        tick();
    endtask

    task automatic idle(input logic ce_v);
        drive(1'b0, ce_v, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic expect_lit(input string tag, input logic [DW-1:0] s,
                              input logic [2*NL-1:0] c, input logic v);
        vectors++;
        assert (bus.S === s && bus.COUT === c && bus.out_valid === v) else begin
            miscompares++;
            $error("FAIL %s: got S=%h COUT=%b vld=%b exp S=%h COUT=%b vld=%b",
                   tag, bus.S, bus.COUT, bus.out_valid, s, c, v);
        end
    endtask

    initial begin
        exp_t e0;
        e0  = '0;
        cur = '0;
        pm  = '0;
        v1m = 1'b0;
        v2m = 1'b0;
        reset = 1'b1;
        bus.ce = 1'b1; bus.in_valid = 1'b0; bus.USE_SIMD = 2'b00; bus.op = 2'b00;
        bus.acc = 1'b0; bus.acc_clr = 1'b0; bus.CIN = 1'b0;
        bus.X = '0; bus.Y = '0; bus.Z = '0;
        @(posedge clk); @(posedge clk); #1;
        expect_lit("reset_state", '0, '0, 1'b0);
        reset = 1'b0;
        idle(1'b1);

        // full-word sum wrapping into the top-lane carry
        drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 30'h3FFFFFFF, 30'd1, 30'd0);
        expect_lit("t1_latency1", '0, '0, 1'b0);
        idle(1'b1);
        expect_lit("t1_full_word", 30'd0, 10'b01_00_00_00_00, 1'b1);

        drive(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b1, 30'h3FFFFFFF, 30'h3FFFFFFF, 30'h3FFFFFFF);
        idle(1'b1);
        expect_lit("t2_per_lane", {5{6'h3E}}, {5{2'b10}}, 1'b1);

        drive(1'b1, 1'b1, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 30'h0000003F, 30'd1, 30'd0);
        idle(1'b1);
        expect_lit("t3_lane_pairs", 30'h040, 10'd0, 1'b1);

        // accumulation chain with no bubbles
        drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 30'd5, 30'd0, 30'h1234);
        drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 30'd5, 30'd0, 30'h1234);
        expect_lit("t4_acc5", 30'd5, 10'd0, 1'b1);
        drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 30'd5, 30'd0, 30'h1234);
        expect_lit("t4_acc10", 30'd10, 10'd0, 1'b1);
        drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 30'd5, 30'd0, 30'h1234);
        expect_lit("t4_acc15", 30'd15, 10'd0, 1'b1);
        idle(1'b1);
        expect_lit("t4_acc20", 30'd20, 10'd0, 1'b1);

        // acc_clr without acc, bitwise with P feedback, back-to-back grouping changes
        drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1, 30'd7, 30'd8, 30'd9);
        drive(1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b1, 30'h0F0F0F0F, 30'h00FF00FF, 30'd0);
        drive(1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 1'b0, 1'b1, 30'h3F03F03F, 30'h3F0003F, 30'h2AAAAAAA);
        drive(1'b1, 1'b1, 2'b00, 2'b10, 1'b0, 1'b0, 1'b1, 30'h12345678, 30'h0FF0FF0F, 30'd0);
        drive(1'b1, 1'b1, 2'b01, 2'b11, 1'b0, 1'b0, 1'b0, 30'h01010101, 30'h10101010, 30'd0);
        idle(1'b1);
        idle(1'b1);

        // clock-enable stall mid-stream; in_valid offered while stalled is ignored
        drive(1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1, 1'b1, 30'h3FFFFFFF, 30'h0000FFFF, 30'd0);
        drive(1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 30'h00000FFF, 30'h3F000000, 30'd0);
        drive(1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 30'h15555555, 30'd3, 30'd4);
        drive(1'b1, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 30'h15555555, 30'd3, 30'd4);
        drive(1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1, 30'h15555555, 30'd3, 30'd4);
        drive(1'b1, 1'b1, 2'b10, 2'b00, 1'b1, 1'b0, 1'b1, 30'h01041041, 30'd0, 30'd0);
        idle(1'b1);
        idle(1'b1);

        // randomized mix including stalls and idle cycles
        for (int k = 0; k < 40; k++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                  2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
                  1'($urandom), 30'($urandom), 30'($urandom), 30'($urandom));
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // reset pulse with two ops in flight
        drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 30'h1111, 30'h2222, 30'h3333);
        drive(1'b1, 1'b1, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 30'h0ABCDEF, 30'h0123456, 30'd1);
        reset = 1'b1;
        #1;
        expect_lit("t6_reset_immediate", '0, '0, 1'b0);
        exp_q.delete();
        cur = e0;
        pm  = '0;
        v1m = 1'b0;
        v2m = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1'b1);
        expect_lit("t6_no_stale1", '0, '0, 1'b0);
        idle(1'b1);
        expect_lit("t6_no_stale2", '0, '0, 1'b0);
        drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 30'd3, 30'd0, 30'd0);
        idle(1'b1);
        expect_lit("t6_p_cleared", 30'd3, 10'd0, 1'b1);
        idle(1'b1);

        vectors++;
        assert (exp_q.size() == 0) else begin
            miscompares++;
            $error("FAIL drain: got %0d results outstanding exp 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
